// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, operand select and load-use detect.
// Ports:
//   clk, reset (sync, active-high), stall (hold), flush (load bubble)
//   id_*            decoded instruction fields and control from ID
//   exmem_*/memwb_* forwarding sources from later stages
//   alu_a/alu_b/alu_ctrl  ALU operand bus; store_data forwarded rt value
//   dest_reg, branch_target, ex_* control bits for EX and beyond
//   load_use_stall  hazard request back to IF/ID (combinational)
module id_ex_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc4,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             id_alu_src,
    input  logic             id_shift_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] store_data,
    output logic [RADDR-1:0] dest_reg,
    output logic [WIDTH-1:0] branch_target,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             load_use_stall
);

    localparam int unsigned SHAMT_W = 5;
    localparam logic [3:0]  ALU_ADD = 4'b0010;

    logic [WIDTH-1:0] ex_pc4;
    logic [WIDTH-1:0] ex_rs_data;
    logic [WIDTH-1:0] ex_rt_data;
    logic [WIDTH-1:0] ex_imm;
    logic [4:0]       ex_shamt;
    logic [RADDR-1:0] ex_rs;
    logic [RADDR-1:0] ex_rt;
    logic [RADDR-1:0] ex_rd;
    logic [3:0]       ex_alu_ctrl;
    logic             ex_alu_src;
    logic             ex_shift_src;
    logic             ex_reg_dst;

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    // Pipeline register; a bubble is identical to the reset contents and uses the add code.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid      <= 1'b0;
            ex_pc4        <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_shamt      <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_alu_ctrl   <= ALU_ADD;
            ex_alu_src    <= 1'b0;
            ex_shift_src  <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_pc4        <= id_pc4;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_shamt      <= id_shamt;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_alu_ctrl   <= id_alu_ctrl;
            ex_alu_src    <= id_alu_src;
            ex_shift_src  <= id_shift_src;
            ex_reg_dst    <= id_reg_dst;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_branch     <= id_branch;
        end
    end

    // Forwarding: youngest producer (EX/MEM) wins; $zero is never forwarded.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (ex_rs != '0 && exmem_reg_write && exmem_rd == ex_rs) begin
            fwd_rs = exmem_result;
        end else if (ex_rs != '0 && memwb_reg_write && memwb_rd == ex_rs) begin
            fwd_rs = memwb_result;
        end

        fwd_rt = ex_rt_data;
        if (ex_rt != '0 && exmem_reg_write && exmem_rd == ex_rt) begin
            fwd_rt = exmem_result;
        end else if (ex_rt != '0 && memwb_reg_write && memwb_rd == ex_rt) begin
            fwd_rt = memwb_result;
        end
    end

    // Operand select and EX-side derived values.
    assign alu_a         = ex_shift_src ? {{(WIDTH-SHAMT_W){1'b0}}, ex_shamt} : fwd_rs;
    assign alu_b         = ex_alu_src ? ex_imm : fwd_rt;
    assign alu_ctrl      = ex_alu_ctrl;
    assign store_data    = fwd_rt;
    assign dest_reg      = ex_reg_dst ? ex_rd : ex_rt;
    assign branch_target = ex_pc4 + {ex_imm[WIDTH-3:0], 2'b00};

    // Load in EX whose destination is read by the instruction in ID.
    assign load_use_stall = ex_valid & ex_mem_read & (ex_rt != '0)
                          & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_shift_src, id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, store_data, branch_target;
    logic [3:0]  alu_ctrl;
    logic [4:0]  dest_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic        load_use_stall;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_shift_src(id_shift_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .store_data(store_data),
        .dest_reg(dest_reg), .branch_target(branch_target), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .load_use_stall(load_use_stall)
    );

    // Reference model: the instruction currently sitting in EX.
    typedef struct {
        logic        valid;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  shamt, rs, rt, rd;
        logic [3:0]  alu_ctrl;
        logic        alu_src, shift_src, reg_dst, rw, mr, mw, m2r, br;
    } instr_t;

    instr_t m;

    function automatic instr_t bubble();
        instr_t b;
        b = '{valid: 1'b0, pc4: 0, rs_data: 0, rt_data: 0, imm: 0, shamt: 0, rs: 0, rt: 0,
              rd: 0, alu_ctrl: 4'd2, alu_src: 1'b0, shift_src: 1'b0, reg_dst: 1'b0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, br: 1'b0};
        return b;
    endfunction

    function automatic instr_t from_id();
        instr_t c;
        c = '{valid: id_valid, pc4: id_pc4, rs_data: id_rs_data, rt_data: id_rt_data,
              imm: id_imm, shamt: id_shamt, rs: id_rs, rt: id_rt, rd: id_rd,
              alu_ctrl: id_alu_ctrl, alu_src: id_alu_src, shift_src: id_shift_src,
              reg_dst: id_reg_dst, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
              m2r: id_mem_to_reg, br: id_branch};
        return c;
    endfunction

    // Value a register read would see once in-flight writes are accounted for.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] file_val);
        if (r == 0) return file_val;
        if (exmem_reg_write && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd == r) return memwb_result;
        return file_val;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ra, rb;
        #1;
        ra = operand(m.rs, m.rs_data);
        rb = operand(m.rt, m.rt_data);
        chk({tag, ".alu_a"}, alu_a, m.shift_src ? 32'(m.shamt) : ra);
        chk({tag, ".alu_b"}, alu_b, m.alu_src ? m.imm : rb);
        chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m.alu_ctrl));
        chk({tag, ".store_data"}, store_data, rb);
        chk({tag, ".dest_reg"}, 32'(dest_reg), 32'(m.reg_dst ? m.rd : m.rt));
        chk({tag, ".branch_target"}, branch_target, m.pc4 + m.imm * 32'd4);
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(m.rw));
        chk({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(m.mr));
        chk({tag, ".ex_mem_write"}, 32'(ex_mem_write), 32'(m.mw));
        chk({tag, ".ex_mem_to_reg"}, 32'(ex_mem_to_reg), 32'(m.m2r));
        chk({tag, ".ex_branch"}, 32'(ex_branch), 32'(m.br));
        chk({tag, ".load_use_stall"}, 32'(load_use_stall),
            32'(m.valid && m.mr && m.rt != 0 && (m.rt == id_rs || m.rt == id_rt)));
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        instr_t nxt;
        if (reset || flush) nxt = bubble();
        else if (stall)     nxt = m;
        else                nxt = from_id();
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic rand_id(input bit small_regs);
        id_valid      = 1'($urandom);
        id_pc4        = $urandom;
        id_rs_data    = $urandom;
        id_rt_data    = $urandom;
        id_imm        = $urandom;
        id_shamt      = 5'($urandom);
        id_rs         = small_regs ? 5'($urandom_range(0, 7)) : 5'($urandom);
        id_rt         = small_regs ? 5'($urandom_range(0, 7)) : 5'($urandom);
        id_rd         = 5'($urandom);
        id_alu_ctrl   = 4'($urandom);
        id_alu_src    = 1'($urandom);
        id_shift_src  = 1'($urandom);
        id_reg_dst    = 1'($urandom);
        id_reg_write  = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_branch     = 1'($urandom);
    endtask

    task automatic rand_fwd();
        exmem_reg_write = 1'($urandom);
        memwb_reg_write = 1'($urandom);
        exmem_rd        = 5'($urandom_range(0, 7));
        memwb_rd        = 5'($urandom_range(0, 7));
        exmem_result    = $urandom;
        memwb_result    = $urandom;
    endtask

    task automatic plain_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        rand_id(1'b0);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_alu_ctrl = 4'b0010; id_alu_src = 1'b0; id_shift_src = 1'b0; id_reg_dst = 1'b1;
        id_mem_read = 1'b0; id_mem_write = 1'b0; id_branch = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_id(1'b0); rand_fwd();

        // Reset held for two cycles with random ID inputs.
        for (int i = 0; i < 2; i++) begin
            step(); check_all("reset");
            rand_id(1'b0); rand_fwd();
        end
        chk("reset.alu_ctrl_add", 32'(alu_ctrl), 32'h2);
        chk("reset.alu_a_zero", alu_a, 32'h0);
        reset = 1'b0;

        // Plain add, no forward match.
        plain_alu(5'd1, 5'd2, 5'd3);
        id_rs_data = 32'd5; id_rt_data = 32'd7;
        exmem_reg_write = 1'b1; exmem_rd = 5'd10; memwb_reg_write = 1'b1; memwb_rd = 5'd11;
        step(); check_all("add");
        chk("add.alu_a", alu_a, 32'd5);
        chk("add.alu_b", alu_b, 32'd7);
        chk("add.dest_reg", 32'(dest_reg), 32'd3);

        // Both forward sources match rs; EX/MEM wins, then MEM/WB alone.
        plain_alu(5'd3, 5'd4, 5'd5);
        id_rs_data = 32'h55;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
        check_all("dbl");
        chk("dbl.exmem_wins", alu_a, 32'h11);
        exmem_reg_write = 1'b0;
        check_all("dbl_mw");
        chk("dbl.memwb", alu_a, 32'h22);

        // Register zero is never forwarded.
        plain_alu(5'd0, 5'd4, 5'd5);
        id_rs_data = 32'h55;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_reg_write = 1'b1; memwb_rd = 5'd0;
        check_all("r0");
        chk("r0.no_fwd", alu_a, 32'h55);

        // sll with rt forwarded from MEM/WB.
        plain_alu(5'd0, 5'd5, 5'd6);
        id_shift_src = 1'b1; id_shamt = 5'd4;
        step();
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h1;
        check_all("sll");
        chk("sll.alu_a", alu_a, 32'd4);
        chk("sll.alu_b", alu_b, 32'd1);

        // sw-style: immediate on Bin, forwarded rt on store data.
        plain_alu(5'd1, 5'd6, 5'd0);
        id_alu_src = 1'b1; id_imm = 32'd8; id_mem_write = 1'b1;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_result = 32'hAB;
        check_all("sw");
        chk("sw.alu_b", alu_b, 32'd8);
        chk("sw.store_data", store_data, 32'hAB);

        // Load-use hazard, then the bubble clears it.
        plain_alu(5'd2, 5'd9, 5'd0);
        id_mem_read = 1'b1; id_reg_dst = 1'b0;
        step();
        id_rs = 5'd9; id_rt = 5'd4;
        check_all("lu");
        chk("lu.stall", 32'(load_use_stall), 32'd1);
        flush = 1'b1;
        step(); flush = 1'b0;
        check_all("lu_flush");
        chk("lu_flush.valid", 32'(ex_valid), 32'd0);
        chk("lu_flush.stall", 32'(load_use_stall), 32'd0);

        // Stall for three cycles while ID churns.
        rand_id(1'b0); id_alu_ctrl = 4'h7;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        step(); check_all("cap");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id(1'b0);
            step(); check_all("stall");
            chk("stall.alu_ctrl_held", 32'(alu_ctrl), 32'h7);
        end
        flush = 1'b1;
        step(); stall = 1'b0; flush = 1'b0;
        check_all("fl_st");
        chk("fl_st.alu_ctrl", 32'(alu_ctrl), 32'h2);
        chk("fl_st.valid", 32'(ex_valid), 32'd0);

        // beq with negative offset.
        plain_alu(5'd1, 5'd2, 5'd0);
        id_branch = 1'b1; id_pc4 = 32'h100; id_imm = 32'hFFFF_FFFF;
        step(); check_all("beq");
        chk("beq.target", branch_target, 32'hFC);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rand_id(1'b1); rand_fwd();
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            step();
            reset = 1'b0; flush = 1'b0; stall = 1'b0;
            rand_fwd();
            rand_id(1'b1);
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection for the 5-stage MIPS pipeline.
- Registers decoded operands and control from ID, then resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU operand bus (Ain, Bin, ALUControl), store data, destination register and branch target for EX.
- Detects load-use hazards for the hazard/stall logic.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current ID/EX contents
- flush  in  1  load a bubble on next edge
- id_valid  in  1  ID holds a real instruction
- id_pc4  in  WIDTH  PC+4 of ID instruction
- id_rs_data, id_rt_data  in  WIDTH  register file read data
- id_imm  in  WIDTH  sign/zero-extended immediate
- id_shamt  in  5  shift amount field
- id_rs, id_rt, id_rd  in  RADDR  register specifiers
- id_alu_ctrl  in  4  ALU control code
- id_alu_src  in  1  1: Bin = imm
- id_shift_src  in  1  1: Ain = shamt (sll/srl/sra)
- id_reg_dst  in  1  1: dest = rd, 0: dest = rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control bits
- exmem_reg_write  in  1;  exmem_rd  in  RADDR;  exmem_result  in  WIDTH  EX/MEM forward source
- memwb_reg_write  in  1;  memwb_rd  in  RADDR;  memwb_result  in  WIDTH  MEM/WB forward source
- alu_a, alu_b  out  WIDTH  to ALU Ain/Bin
- alu_ctrl  out  4  to ALU ALUControl
- store_data  out  WIDTH  forwarded rt value
- dest_reg  out  RADDR  write-back register
- branch_target  out  WIDTH  pc4 + (imm<<2)
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each
- load_use_stall  out  1  hazard request to IF/ID

Behaviour:
- State is one register bank holding every id_* input; 1-cycle latency from ID to EX outputs.
- Edge priority: reset > flush > stall > load.
- Reset:
  - all data fields and register specifiers 0;
  - all control bits 0, ex_valid 0;
  - stored alu_ctrl = 4'b0010 (add);
  - therefore alu_a = alu_b = 0, alu_ctrl = 0010, load_use_stall = 0.
- Flush (including flush with stall): load a bubble identical to the reset contents. A bubble never produces the ALU's unknown-code path.
- Stall without flush: hold all contents unchanged. Outputs still re-evaluate forwarding each cycle, because forward sources move.
- Otherwise: capture id_* on every edge.
- Forwarding (combinational, per operand rs/rt, on registered specifier r):
  - if exmem_reg_write and exmem_rd == r and r != 0: use exmem_result;
  - else if memwb_reg_write and memwb_rd == r and r != 0: use memwb_result;
  - else use the registered read data;
  - EX/MEM always wins over MEM/WB when both match;
  - register 0 is never forwarded.
- Operand select:
  - alu_a = shift_src ? {27'b0, shamt} : fwd_rs;
  - alu_b = alu_src ? imm : fwd_rt;
  - store_data = fwd_rt, regardless of alu_src.
- dest_reg = reg_dst ? rd : rt.
- branch_target = pc4 + {imm[29:0], 2'b00}, modulo 2^32, wrap ignored.
- load_use_stall = ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - Combinational from ID inputs and registered state.
  - The top level must respond with flush to this stage plus hold of PC and IF/ID. After one bubble the condition clears, since the bubble has ex_mem_read = 0.
- Control outputs are the registered bits directly; no gating by ex_valid is needed, because bubbles clear them.

Test Plan:
- Reset held 2 cycles with random id_* inputs -> alu_a = 0, alu_b = 0, alu_ctrl = 0010, all control outs 0, load_use_stall = 0.
- ID add: rs_data = 5, rt_data = 7, alu_src = 0, no forward match -> next cycle alu_a = 5, alu_b = 7, alu_ctrl = 0010, dest_reg = rd.
- Double match: registered rs = 3, exmem_rd = 3 with result 0x11, memwb_rd = 3 with result 0x22, both write -> alu_a = 0x11. Drop exmem_reg_write -> alu_a = 0x22. Set rs = 0 with the same matches -> alu_a = registered rs_data.
- sll: shift_src = 1, shamt = 4, rt forwarded from MEM/WB = 0x1 -> alu_a = 4, alu_b = 1. sw-style: alu_src = 1, imm = 8, rt forwarded 0xAB -> alu_b = 8, store_data = 0xAB.
- Load-use: EX holds lw with rt = 9, ID rs = 9 -> load_use_stall = 1. Assert flush -> next cycle ex_valid = 0, ex_mem_read = 0, load_use_stall = 0.
- Stall held 3 cycles while id_* changes -> outputs stay constant. Flush and stall in the same cycle -> bubble loaded. beq with pc4 = 0x100, imm = 0xFFFFFFFF -> branch_target = 0xFC.
